// File: rtl/serial_link_pkg.sv
// Shared definitions for the shift_enable/serial_in byte link (serializer and receiver).
package serial_link_pkg;

    localparam int unsigned DEFAULT_DATA_W = 8;
    localparam bit          MSB_FIRST      = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SHIFT  = 2'd1,
        ST_PARITY = 2'd2,
        ST_DONE   = 2'd3
    } state_e;

endpackage

// File: rtl/bit_timer.sv
// Bit-period divider: counts CLKS_PER_BIT clocks per bit and flags the last cycle of each period.
module bit_timer #(
    parameter int unsigned CLKS_PER_BIT = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic bit_tick
);

    localparam int unsigned CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] div_cnt_q, div_cnt_d;

    always_comb begin
        bit_tick  = enable && (div_cnt_q == LAST);
        div_cnt_d = div_cnt_q;
        if (clear) begin
            div_cnt_d = '0;
        end else if (enable) begin
            div_cnt_d = bit_tick ? '0 : div_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt_q <= '0;
        end else begin
            div_cnt_q <= div_cnt_d;
        end
    end

endmodule

// File: rtl/byte_serializer.sv
// Parallel-in, serial-out word transmitter with shift_enable strobe.
// Define BYTE_SERIALIZER_PARITY_EN to append an even-parity bit after each word.
module byte_serializer
    import serial_link_pkg::*;
#(
    parameter int unsigned DATA_W       = DEFAULT_DATA_W,
    parameter int unsigned CLKS_PER_BIT = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              serial_out,
    output logic              shift_enable,
    output logic              busy,
    output logic              done
);

    localparam int unsigned BIT_CNT_W = $clog2(DATA_W);
    localparam logic [BIT_CNT_W-1:0] LAST_BIT = BIT_CNT_W'(DATA_W - 1);

    state_e                state_q, state_d;
    logic [DATA_W-1:0]     sreg_q, sreg_d;
    logic [BIT_CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
    logic                  serial_q, serial_d;
    logic                  shen_q, shen_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic                  accept;
    logic                  bit_tick;
    logic [DATA_W-1:0]     sreg_shifted;
`ifdef BYTE_SERIALIZER_PARITY_EN
    logic                  parity_q, parity_d;
`endif

    assign in_ready     = (state_q == ST_IDLE);
    assign accept       = in_valid && in_ready;
    assign serial_out   = serial_q;
    assign shift_enable = shen_q;
    assign busy         = busy_q;
    assign done         = done_q;

    bit_timer #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_bit_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (accept),
        .enable  ((state_q == ST_SHIFT) || (state_q == ST_PARITY)),
        .bit_tick(bit_tick)
    );

    always_comb begin
        state_d      = state_q;
        sreg_d       = sreg_q;
        bit_cnt_d    = bit_cnt_q;
        serial_d     = serial_q;
        shen_d       = shen_q;
        done_d       = 1'b0;
        sreg_shifted = MSB_FIRST ? (sreg_q << 1) : (sreg_q >> 1);
`ifdef BYTE_SERIALIZER_PARITY_EN
        parity_d     = parity_q;
`endif
        unique case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    state_d   = ST_SHIFT;
                    sreg_d    = in_data;
                    bit_cnt_d = '0;
                    serial_d  = MSB_FIRST ? in_data[DATA_W-1] : in_data[0];
                    shen_d    = 1'b1;
`ifdef BYTE_SERIALIZER_PARITY_EN
                    parity_d  = ^in_data;
`endif
                end
            end
            ST_SHIFT: begin
                if (bit_tick) begin
                    if (bit_cnt_q == LAST_BIT) begin
`ifdef BYTE_SERIALIZER_PARITY_EN
                        state_d  = ST_PARITY;
                        serial_d = parity_q;
`else
                        state_d  = ST_DONE;
                        serial_d = 1'b0;
                        shen_d   = 1'b0;
                        done_d   = 1'b1;
`endif
                    end else begin
                        sreg_d    = sreg_shifted;
                        bit_cnt_d = bit_cnt_q + 1'b1;
                        serial_d  = MSB_FIRST ? sreg_shifted[DATA_W-1] : sreg_shifted[0];
                    end
                end
            end
            ST_PARITY: begin
                if (bit_tick) begin
                    state_d  = ST_DONE;
                    serial_d = 1'b0;
                    shen_d   = 1'b0;
                    done_d   = 1'b1;
                end
            end
            ST_DONE: begin
                state_d  = ST_IDLE;
                serial_d = 1'b0;
                shen_d   = 1'b0;
            end
            default: state_d = ST_IDLE;
        endcase
        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            sreg_q    <= '0;
            bit_cnt_q <= '0;
            serial_q  <= 1'b0;
            shen_q    <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
`ifdef BYTE_SERIALIZER_PARITY_EN
            parity_q  <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            sreg_q    <= sreg_d;
            bit_cnt_q <= bit_cnt_d;
            serial_q  <= serial_d;
            shen_q    <= shen_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
`ifdef BYTE_SERIALIZER_PARITY_EN
            parity_q  <= parity_d;
`endif
        end
    end

endmodule

// File: tb/tb_byte_serializer.sv
// Testbench for byte_serializer: two instances (CLKS_PER_BIT=1 and 3) checked against a word-level model.
// Honours BYTE_SERIALIZER_PARITY_EN when defined for the build.
module tb_byte_serializer;

`ifdef BYTE_SERIALIZER_PARITY_EN
    localparam int NBITS = 9;
`else
    localparam int NBITS = 8;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] in_data [2];
    logic       in_valid [2];
    logic       in_ready [2];
    logic       serial_out [2];
    logic       shift_enable [2];
    logic       busy [2];
    logic       done [2];

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    byte_serializer #(
        .DATA_W      (8),
        .CLKS_PER_BIT(1)
    ) u_dut0 (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_data     (in_data[0]),
        .in_valid    (in_valid[0]),
        .in_ready    (in_ready[0]),
        .serial_out  (serial_out[0]),
        .shift_enable(shift_enable[0]),
        .busy        (busy[0]),
        .done        (done[0])
    );

    byte_serializer #(
        .DATA_W      (8),
        .CLKS_PER_BIT(3)
    ) u_dut1 (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_data     (in_data[1]),
        .in_valid    (in_valid[1]),
        .in_ready    (in_ready[1]),
        .serial_out  (serial_out[1]),
        .shift_enable(shift_enable[1]),
        .busy        (busy[1]),
        .done        (done[1])
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_idle_outputs(input int d, input string tag);
        check_val({tag, "_ready"}, 32'(in_ready[d]), 1);
        check_val({tag, "_busy"}, 32'(busy[d]), 0);
        check_val({tag, "_shen"}, 32'(shift_enable[d]), 0);
        check_val({tag, "_serial"}, 32'(serial_out[d]), 0);
        check_val({tag, "_done"}, 32'(done[d]), 0);
    endtask

    // Called at a negedge; presents a word once the instance is ready (bounded wait).
    task automatic drive(input int d, input logic [7:0] w);
        int n;
        n = 0;
        while (in_ready[d] !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (in_ready[d] !== 1'b1) check_val("ready_timeout", 0, 1);
        in_data[d]  = w;
        in_valid[d] = 1'b1;
    endtask

    // Expects an accept at the next posedge, then checks the whole word against the model.
    task automatic check_word(input int d, input logic [7:0] w, input logic hold,
                              input logic [7:0] nxt);
        int         c;
        int         strobes;
        int         bit_idx;
        logic [7:0] rx;
        logic       exp_bit;
        c       = (d == 0) ? 1 : 3;
        strobes = 0;
        rx      = 8'h00;
        @(posedge clk);
        #1;
        in_valid[d] = hold;
        in_data[d]  = hold ? nxt : 8'($urandom);
        for (int i = 0; i < NBITS * c; i++) begin
            @(negedge clk);
            bit_idx = i / c;
            exp_bit = (bit_idx < 8) ? w[7 - bit_idx] : ^w;
            check_val("serial", 32'(serial_out[d]), 32'(exp_bit));
            check_val("shen", 32'(shift_enable[d]), 1);
            check_val("busy_word", 32'(busy[d]), 1);
            check_val("ready_word", 32'(in_ready[d]), 0);
            check_val("done_early", 32'(done[d]), 0);
            if (shift_enable[d] === 1'b1) strobes++;
            // Receiver samples once per bit period and keeps only the data bits.
            if ((i % c) == c - 1 && bit_idx < 8 && shift_enable[d] === 1'b1)
                rx = {rx[6:0], serial_out[d]};
        end
        @(negedge clk);
        check_val("done_pulse", 32'(done[d]), 1);
        check_val("done_shen", 32'(shift_enable[d]), 0);
        check_val("done_serial", 32'(serial_out[d]), 0);
        check_val("done_busy", 32'(busy[d]), 1);
        check_val("done_ready", 32'(in_ready[d]), 0);
        @(negedge clk);
        check_idle_outputs(d, "after");
        check_val("loopback", 32'(rx), 32'(w));
        check_val("strobes", 32'(strobes), 32'(NBITS * c));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] w;
        int         d;
        for (int k = 0; k < 2; k++) begin
            in_data[k]  = 8'h00;
            in_valid[k] = 1'b0;
        end

        repeat (3) @(negedge clk);
        check_idle_outputs(0, "rst0");
        check_idle_outputs(1, "rst1");
        rst_n = 1'b1;
        @(negedge clk);
        check_idle_outputs(0, "post_rst");

        drive(0, 8'hA6);
        check_word(0, 8'hA6, 1'b0, 8'h00);

        drive(1, 8'h81);
        check_word(1, 8'h81, 1'b0, 8'h00);

        for (int k = 0; k < 2; k++) begin
            drive(k, 8'h3C);
            check_word(k, 8'h3C, 1'b1, 8'hC3);
            check_word(k, 8'hC3, 1'b0, 8'h00);
        end

        // Abort 8'hFF partway into its fifth bit on the slow instance.
        drive(1, 8'hFF);
        @(posedge clk);
        #1;
        in_valid[1] = 1'b0;
        repeat (4 * 3) @(posedge clk);
        #2;
        check_val("pre_abort_serial", 32'(serial_out[1]), 1);
        rst_n = 1'b0;
        #1;
        check_idle_outputs(1, "abort");
        repeat (2) begin
            @(negedge clk);
            check_val("abort_no_done", 32'(done[1]), 0);
        end
        rst_n = 1'b1;
        repeat (5) begin
            @(negedge clk);
            check_val("abort_stays_idle", 32'(done[1] | busy[1]), 0);
        end
        drive(1, 8'h55);
        check_word(1, 8'h55, 1'b0, 8'h00);

        drive(0, 8'h07);
        check_word(0, 8'h07, 1'b0, 8'h00);
        drive(0, 8'h03);
        check_word(0, 8'h03, 1'b0, 8'h00);

        for (int k = 0; k < 12; k++) begin
            d = int'($urandom_range(0, 1));
            w = 8'($urandom);
            drive(d, w);
            check_word(d, w, 1'b0, 8'h00);
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
